// File: rtl/video_scanout.sv
// rtl/video_scanout.sv - VRAM scanout: 640x480 raster timing, scaled VRAM walk, DAC outputs (option: SCANOUT_BORDER_EN)
module video_scanout #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int V_OFFSET  = 80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hires,
  output logic [6:0] vram_hpos,
  output logic [5:0] vram_vpos,
  input  logic [1:0] vram_pixelo,
  output logic [1:0] pixel,
  output logic       de,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);

  localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int PF_LINES = 320;
  localparam int HW       = $clog2(H_TOTAL);
  localparam int VW       = $clog2(V_TOTAL);

  localparam logic [HW-1:0] C_H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] C_H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] C_HS_START = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] C_HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] C_V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] C_V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] C_VS_START = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] C_VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] C_PF_TOP   = VW'(V_OFFSET);
  localparam logic [VW-1:0] C_PF_END   = VW'(V_OFFSET + PF_LINES);

`ifdef SCANOUT_BORDER_EN
  localparam logic [1:0] C_BORDER = 2'b01;
`else
  localparam logic [1:0] C_BORDER = 2'b00;
`endif

  // raster position and frame mode
  logic [HW-1:0] r_hcount;
  logic [VW-1:0] r_vcount;
  logic          r_hires_q;

  // VRAM cell walk: sub counts pixels within a cell, cell is the VRAM coordinate
  logic [3:0] r_xsub;
  logic [6:0] r_xcell;
  logic [3:0] r_ysub;
  logic [5:0] r_ycell;

  // stage 1: address and raster flags for the position one clock ago
  logic [6:0] r_vram_hpos;
  logic [5:0] r_vram_vpos;
  logic       r_vis1;
  logic       r_pf1;
  logic       r_hs1;
  logic       r_vs1;
  logic       r_frame_start;

  // stage 2: flags lined up with the VRAM read data
  logic r_de;
  logic r_pf2;
  logic r_hsync;
  logic r_vsync;

  logic          w_h_last;
  logic          w_v_last;
  logic [VW-1:0] w_v_next;
  logic          w_origin;
  logic [3:0]    w_sub_last;
  logic          w_in_rows;
  logic          w_vis;
  logic          w_pf;
  logic          w_hs;
  logic          w_vs;
  logic [1:0]    w_pixel;

  assign w_h_last   = (r_hcount == C_H_LAST);
  assign w_v_last   = (r_vcount == C_V_LAST);
  assign w_v_next   = w_v_last ? '0 : r_vcount + VW'(1);
  assign w_origin   = (r_hcount == '0) && (r_vcount == '0);
  // cell is 5 pixels square in hires (128x64), 10 in lores (64x32)
  assign w_sub_last = r_hires_q ? 4'd4 : 4'd9;
  assign w_in_rows  = (r_vcount >= C_PF_TOP) && (r_vcount < C_PF_END);
  assign w_vis      = (r_hcount < C_H_VIS) && (r_vcount < C_V_VIS);
  assign w_pf       = w_vis && w_in_rows;
  assign w_hs       = (r_hcount >= C_HS_START) && (r_hcount < C_HS_END);
  assign w_vs       = (r_vcount >= C_VS_START) && (r_vcount < C_VS_END);

  // horizontal and vertical raster counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_h_last) begin
      r_hcount <= '0;
      r_vcount <= w_v_next;
    end else begin
      r_hcount <= r_hcount + HW'(1);
    end
  end

  // display mode is latched once per frame so a mid-frame change cannot tear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hires_q <= 1'b0;
    end else if (w_origin) begin
      r_hires_q <= hires;
    end
  end

  // column walk restarts every line; xcell past the visible area is never used
  always_ff @(posedge clk) begin
    if (reset || w_h_last) begin
      r_xsub  <= 4'd0;
      r_xcell <= 7'd0;
    end else if (r_xsub == w_sub_last) begin
      r_xsub  <= 4'd0;
      r_xcell <= r_xcell + 7'd1;
    end else begin
      r_xsub  <= r_xsub + 4'd1;
    end
  end

  // row walk restarts at the first playfield line and advances once per playfield line
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ysub  <= 4'd0;
      r_ycell <= 6'd0;
    end else if (w_h_last) begin
      if (w_v_next == C_PF_TOP) begin
        r_ysub  <= 4'd0;
        r_ycell <= 6'd0;
      end else if (w_in_rows) begin
        if (r_ysub == w_sub_last) begin
          r_ysub  <= 4'd0;
          r_ycell <= r_ycell + 6'd1;
        end else begin
          r_ysub  <= r_ysub + 4'd1;
        end
      end
    end
  end

  // stage 1: drive the VRAM address and carry the raster flags alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vram_hpos   <= 7'd0;
      r_vram_vpos   <= 6'd0;
      r_vis1        <= 1'b0;
      r_pf1         <= 1'b0;
      r_hs1         <= 1'b0;
      r_vs1         <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_vram_hpos   <= r_xcell;
      r_vram_vpos   <= r_ycell;
      r_vis1        <= w_vis;
      r_pf1         <= w_pf;
      r_hs1         <= w_hs;
      r_vs1         <= w_vs;
      r_frame_start <= w_origin;
    end
  end

  // stage 2: flags arrive together with the VRAM read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_de    <= 1'b0;
      r_pf2   <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_de    <= r_vis1;
      r_pf2   <= r_pf1;
      r_hsync <= r_hs1;
      r_vsync <= r_vs1;
    end
  end

  // colour select: VRAM data inside the playfield, border elsewhere, black in blanking
  always_comb begin
    w_pixel = 2'b00;
    if (r_de) begin
      w_pixel = r_pf2 ? vram_pixelo : C_BORDER;
    end
  end

  assign vram_hpos   = r_vram_hpos;
  assign vram_vpos   = r_vram_vpos;
  assign pixel       = w_pixel;
  assign de          = r_de;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_scanout.sv
// tb/tb_video_scanout.sv - self-checking bench for video_scanout on a shortened raster
module tb_video_scanout;

  localparam int HV = 40;
  localparam int HF = 2;
  localparam int HS = 4;
  localparam int HB = 2;
  localparam int VV = 336;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int VO = 8;
  localparam int PF = 320;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;

`ifdef SCANOUT_BORDER_EN
  localparam logic [1:0] BORDER = 2'b01;
`else
  localparam logic [1:0] BORDER = 2'b00;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       hires;
  logic [6:0] vram_hpos;
  logic [5:0] vram_vpos;
  logic [1:0] vram_pixelo;
  logic [1:0] pixel;
  logic       de;
  logic       hsync;
  logic       vsync;
  logic       frame_start;

  logic [1:0] mem [64][128];

  int errors = 0;
  int checks = 0;
  int k;
  int mode [4];
  int hs_cnt [2];
  int vs_cnt [2];
  int de_cnt [2];
  int fs_cnt [2];
  int p3_cnt [2];
  int p3_hmin [2];
  int p3_hmax [2];
  int p3_vmin [2];
  int p3_vmax [2];

  always #5 clk = ~clk;

  // synchronous-read VRAM: data for an address appears one clock later
  always @(posedge clk) vram_pixelo <= mem[vram_vpos][vram_hpos];

  video_scanout #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .V_OFFSET(VO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hires(hires),
    .vram_hpos(vram_hpos),
    .vram_vpos(vram_vpos),
    .vram_pixelo(vram_pixelo),
    .pixel(pixel),
    .de(de),
    .hsync(hsync),
    .vsync(vsync),
    .frame_start(frame_start)
  );

  // expected {pixel, de, hsync, vsync} for raster position index p since restart
  function automatic logic [4:0] exp_raster(input int p);
    int h, v, s;
    logic d, hs_e, vs_e;
    logic [1:0] px;
    if (p < 0) return 5'b0;
    h = p % HT;
    v = (p / HT) % VT;
    s = (mode[p / FRAME] != 0) ? 5 : 10;
    d = (h < HV) && (v < VV);
    hs_e = (h >= HV + HF) && (h < HV + HF + HS);
    vs_e = (v >= VV + VF) && (v < VV + VF + VS);
    px = 2'b00;
    if (d && v >= VO && v < VO + PF) px = mem[(v - VO) / s][h / s];
    else if (d) px = BORDER;
    return {px, d, hs_e, vs_e};
  endfunction

  task automatic check_cycle();
    logic [4:0] exp_o;
    logic       fs_exp;
    int p, h, v, s, f;
    exp_o = exp_raster(k - 2);
    checks++;
    assert ({pixel, de, hsync, vsync} === exp_o) else begin
      errors++;
      $error("FAIL raster k=%0d observed=%b required=%b", k, {pixel, de, hsync, vsync}, exp_o);
    end
    fs_exp = (k >= 1) && ((k - 1) % FRAME == 0);
    checks++;
    assert (frame_start === fs_exp) else begin
      errors++;
      $error("FAIL frame_start k=%0d observed=%b required=%b", k, frame_start, fs_exp);
    end
    if (k >= 1) begin
      p = k - 1;
      h = p % HT;
      v = (p / HT) % VT;
      s = (mode[p / FRAME] != 0) ? 5 : 10;
      if (h < HV && v >= VO && v < VO + PF) begin
        checks++;
        assert ({vram_hpos, vram_vpos} === {7'(h / s), 6'((v - VO) / s)}) else begin
          errors++;
          $error("FAIL address k=%0d observed=%0d,%0d required=%0d,%0d",
                 k, vram_hpos, vram_vpos, h / s, (v - VO) / s);
        end
      end
      f = p / FRAME;
      if (f < 2 && frame_start) fs_cnt[f]++;
    end
    if (k >= 2) begin
      p = k - 2;
      f = p / FRAME;
      h = p % HT;
      v = (p / HT) % VT;
      if (f < 2) begin
        if (hsync) hs_cnt[f]++;
        if (vsync) vs_cnt[f]++;
        if (de) de_cnt[f]++;
        if (pixel == 2'd3) begin
          p3_cnt[f]++;
          if (h < p3_hmin[f]) p3_hmin[f] = h;
          if (h > p3_hmax[f]) p3_hmax[f] = h;
          if (v < p3_vmin[f]) p3_vmin[f] = v;
          if (v > p3_vmax[f]) p3_vmax[f] = v;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    k++;
    check_cycle();
    if (k % FRAME == 0) mode[k / FRAME] = int'(hires);
  endtask

  task automatic check_int(input string tag, input int observed, input int required);
    checks++;
    assert (observed === required) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, observed, required);
    end
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    assert ({pixel, de, hsync, vsync, frame_start} === 6'b0) else begin
      errors++;
      $error("FAIL %s outputs observed=%b required=000000", tag, {pixel, de, hsync, vsync, frame_start});
    end
    checks++;
    assert ({vram_hpos, vram_vpos} === 13'd0) else begin
      errors++;
      $error("FAIL %s address observed=%0d,%0d required=0,0", tag, vram_hpos, vram_vpos);
    end
  endtask

  initial begin
    reset = 1'b1;
    hires = 1'b0;
    k = 0;
    for (int i = 0; i < 4; i++) mode[i] = 0;
    for (int f = 0; f < 2; f++) begin
      hs_cnt[f] = 0; vs_cnt[f] = 0; de_cnt[f] = 0; fs_cnt[f] = 0; p3_cnt[f] = 0;
      p3_hmin[f] = 9999; p3_hmax[f] = -1; p3_vmin[f] = 9999; p3_vmax[f] = -1;
    end
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) mem[r][c] = 2'b00;
    mem[0][3] = 2'b11;

    // reset state, then release: frame 0 runs in lores
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    k = 0;
    mode[0] = int'(hires);

    // hires goes 0->1 at line 200; frame 0 must keep lores stepping
    while (k < 200 * HT) cycle();
    hires = 1'b1;

    // frame 1 runs in hires; pick a random mode for frame 2
    while (k < FRAME + 200 * HT) cycle();
    hires = 1'($urandom_range(0, 1));

    // below the playfield of frame 1: load random VRAM contents for frame 2
    while (k < FRAME + 335 * HT) cycle();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 128; c++) mem[r][c] = 2'($urandom_range(0, 3));

    // wait until the outputs for the last position of frame 1 have been seen
    while (k < 2 * FRAME + 1) cycle();
    for (int f = 0; f < 2; f++) begin
      check_int($sformatf("hsync_per_frame%0d", f), hs_cnt[f], HS * VT);
      check_int($sformatf("vsync_per_frame%0d", f), vs_cnt[f], VS * HT);
      check_int($sformatf("de_per_frame%0d", f), de_cnt[f], HV * VV);
      check_int($sformatf("frame_start_per_frame%0d", f), fs_cnt[f], 1);
    end
    check_int("lores_hot_count", p3_cnt[0], 100);
    check_int("lores_hot_hmin", p3_hmin[0], 30);
    check_int("lores_hot_hmax", p3_hmax[0], 39);
    check_int("lores_hot_vmin", p3_vmin[0], VO);
    check_int("lores_hot_vmax", p3_vmax[0], VO + 9);
    check_int("hires_hot_count", p3_cnt[1], 25);
    check_int("hires_hot_hmin", p3_hmin[1], 15);
    check_int("hires_hot_hmax", p3_hmax[1], 19);
    check_int("hires_hot_vmin", p3_vmin[1], VO);
    check_int("hires_hot_vmax", p3_vmax[1], VO + 4);

    // one-clock reset in the middle of frame 2 at hcount=30, vcount=250
    while (k < 2 * FRAME + 250 * HT + 30) cycle();
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midframe_reset");
    reset = 1'b0;
    k = 0;
    mode[0] = int'(hires);

    // raster restarts at 0,0 with random VRAM contents
    while (k < 20 * HT) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
